serial_adder_ctrl: RTL and testbench

// - Bit-serial N-bit adder. It reuses one 1-bit full-adder cell for WIDTH clock cycles.
// - It sequences operand bits LSB-first through the cell and keeps the carry in a flip-flop between bits.
// - It assembles the sum and reports completion with a start/busy/done handshake.
// - It is the area-cheap alternative to a ripple adder and serves narrow/slow arithmetic paths.
//

---
 rtl/serial_adder_ctrl_pkg.sv | 18 +
 rtl/serial_adder_ctrl_full_adder_cell.sv | 14 +
 rtl/serial_adder_ctrl.sv | 110 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// legal WIDTH range, with a helper that checks a WIDTH against that range.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder_cell.sv
// Single-bit full adder. This is the only arithmetic in the serial adder;
// the controller feeds it one bit pair per clock.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder. Operands are shifted LSB-first through one
// full-adder cell, the carry is kept in a flop between bits, and the sum is
// assembled MSB-in/shift-right. start/busy/done handshake; one addition per
// WIDTH+1 cycles when start is held.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  // Reject an out-of-range WIDTH at elaboration.
  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH out of range");
  end

  state_t           state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             cell_s;
  logic             cell_cout;
  logic [WIDTH-1:0] sum_next;

  full_adder_cell u_cell (
    .a    (shift_a[0]),
    .b    (shift_b[0]),
    .cin  (carry),
    .s    (cell_s),
    .cout (cell_cout)
  );

  // New sum bit enters at the MSB and everything moves one place right.
  // The bit falling off the bottom is stale, so the final sum is sum_next
  // taken on the last RUN cycle.
  assign sum_next = WIDTH'({cell_s, sum_sr} >> 1);

  // FSM, counter, operand shifters, carry flop and registered outputs.
  // NOTE: every register here, including the datapath shifters, is cleared
  // by reset so a mid-operation abort leaves no residue for the next add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      shift_a <= '0;
      shift_b <= '0;
      sum_sr  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      cout    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // reads the pre-edge value regardless of statement order.
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            shift_a <= a;
            shift_b <= b;
            carry   <= cin;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end else begin
            state   <= ST_IDLE;
          end
        end
        ST_RUN: begin
          carry   <= cell_cout;
          sum_sr  <= sum_next;
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            s     <= sum_next;
            cout  <= cell_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl. Two instances (WIDTH=8 and
// WIDTH=2) share clock and reset. The reference is plain integer addition
// plus the cycle-level handshake timing: busy for WIDTH cycles after the
// accepting edge, then a single done cycle carrying a+b+cin.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, s8;

  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, s2;

  int checks   = 0;
  int failures = 0;

  // Last completed result per instance, as {cout,s}; the value s/cout must hold.
  logic [8:0] prev8 = '0;
  logic [8:0] prev2 = '0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .s(s2), .cout(cout2)
  );

  task automatic check(input string tag, input logic [10:0] observed,
                       input logic [10:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // {busy, done, {cout,s} zero-extended to 9 bits}
  function automatic logic [10:0] obs(input bit w8);
    return w8 ? {busy8, done8, cout8, s8} : {busy2, done2, 6'b0, cout2, s2};
  endfunction

  task automatic drive(input bit w8, input logic st, input logic [7:0] av,
                       input logic [7:0] bv, input logic ci);
    if (w8) begin
      start8 = st; a8 = av; b8 = bv; cin8 = ci;
    end else begin
      start2 = st; a2 = av[1:0]; b2 = bv[1:0]; cin2 = ci;
    end
  endtask

  // Called at a negedge with the DUT in IDLE or DONE. Issues start, checks
  // busy/held result on every RUN cycle while scrambling the inputs, then
  // checks the done cycle. Returns at the negedge of the done cycle, so an
  // immediate next call is a back-to-back start.
  //   hold      : keep start high through the whole run
  //   pulse_cyc : additionally raise start for one RUN cycle (ignored by DUT)
  task automatic do_op(input bit w8, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci, input bit hold, input int pulse_cyc);
    int         w    = w8 ? 8 : 2;
    logic [8:0] mask = w8 ? 9'h0FF : 9'h003;
    logic [8:0] expv = ({1'b0, av} & mask) + ({1'b0, bv} & mask) + 9'(ci);
    logic [8:0] prev = w8 ? prev8 : prev2;
    logic       st;
    drive(w8, 1'b1, av, bv, ci);
    for (int k = 0; k < w; k++) begin
      @(negedge clk);
      check(w8 ? "run8" : "run2", obs(w8), {2'b10, prev});
      st = hold || (k == pulse_cyc);
      drive(w8, st, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    @(negedge clk);
    check(w8 ? "done8" : "done2", obs(w8), {2'b01, expv});
    drive(w8, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    if (w8) prev8 = expv;
    else    prev2 = expv;
  endtask

  // One idle cycle: done must have dropped and the result must be held.
  task automatic idle(input bit w8);
    @(negedge clk);
    check(w8 ? "idle8" : "idle2", obs(w8), {2'b00, w8 ? prev8 : prev2});
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    check("reset8", obs(1'b1), 11'h000);
    check("reset2", obs(1'b0), 11'h000);
    rst = 1'b0;
    @(negedge clk);

    // Directed WIDTH=8 cases.
    do_op(1'b1, 8'h0F, 8'h01, 1'b0, 1'b0, -1); idle(1'b1);
    do_op(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, -1); idle(1'b1);
    do_op(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, -1); idle(1'b1);
    do_op(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, -1); idle(1'b1);
    // Start pulsed mid-run is ignored; a single done follows.
    do_op(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 3);  idle(1'b1); idle(1'b1);

    // Reset during cycle 4 of an addition aborts it.
    drive(1'b1, 1'b1, 8'h5A, 8'hC3, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort8", obs(1'b1), 11'h000);
    check("abort2", obs(1'b0), 11'h000);
    prev8 = '0;
    prev2 = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_done_after_abort", obs(1'b1), 11'h000);
    end
    do_op(1'b1, 8'h80, 8'h7F, 1'b1, 1'b0, -1); idle(1'b1);

    // Start held high: back-to-back additions every WIDTH+1 cycles.
    for (int i = 0; i < 6; i++)
      do_op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, -1);
    idle(1'b1);

    // Directed WIDTH=2 cases.
    do_op(1'b0, 8'h03, 8'h03, 1'b1, 1'b0, -1); idle(1'b0);
    do_op(1'b0, 8'h01, 8'h02, 1'b0, 1'b0, -1); idle(1'b0);
    do_op(1'b0, 8'h02, 8'h02, 1'b0, 1'b0, 0);  idle(1'b0);

    // Random regression on both widths, mixing gaps, back-to-back starts,
    // held start and ignored mid-run pulses.
    for (int i = 0; i < 1000; i++) begin
      do_op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 9));
      if ($urandom_range(0, 1) == 1) idle(1'b1);
    end
    idle(1'b1);
    for (int i = 0; i < 1000; i++) begin
      do_op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) idle(1'b0);
    end
    idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
